// File: rtl/cache_pkg.sv
// Shared definitions for the victim buffer and its eviction/writeback engine.
// Entry layout is {valid, dirty, addr, data} with the valid bit at the MSB.
package cache_pkg;

    localparam int ENTRY_W      = 80;
    localparam int VB_VALID_BIT = 79;
    localparam int VB_DIRTY_BIT = 78;
    localparam int VB_ADDR_HI   = 77;
    localparam int VB_ADDR_LO   = 64;
    localparam int VB_DATA_HI   = 63;
    localparam int VB_DATA_LO   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_WRITE,
        ST_CLEAR,
        ST_DONE
    } evict_state_e;

endpackage

// File: rtl/victim_writeback.sv
// Frees the victim slot at the eviction pointer: writes back dirty lines, invalidates, then rolls the pointer.
// Latency: 2 cycles (invalid), 3 (clean), ack+2 (dirty); stalls indefinitely in WRITE until mem_ack; evict_req ignored while busy.
module victim_writeback #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int ENTRY_W = ADDR_W + DATA_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               evict_req,
    input  logic [ENTRY_W-1:0] ev_data,
    input  logic [1:0]         ev_index,
    output logic               mem_wr_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    output logic               vb_we,
    output logic [1:0]         vb_wline,
    output logic [ENTRY_W-1:0] vb_wdata,
    output logic               roll,
    output logic               evict_done,
    output logic               busy,
    output logic [15:0]        wb_count
);
    import cache_pkg::*;

    localparam int VALID_BIT = ENTRY_W - 1;
    localparam int DIRTY_BIT = ENTRY_W - 2;

    evict_state_e      state_q, state_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [1:0]        idx_q,   idx_d;
    logic [15:0]       wb_count_q, wb_count_d;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        addr_d     = addr_q;
        data_d     = data_q;
        idx_d      = idx_q;
        wb_count_d = wb_count_q;
        case (state_q)
            ST_IDLE: begin
                if (evict_req) begin
                    valid_d = ev_data[VALID_BIT];
                    dirty_d = ev_data[DIRTY_BIT];
                    addr_d  = ev_data[DATA_W +: ADDR_W];
                    data_d  = ev_data[DATA_W-1:0];
                    idx_d   = ev_index;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!valid_q)     state_d = ST_DONE;
                else if (dirty_q) state_d = ST_WRITE;
                else              state_d = ST_CLEAR;
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d = ST_CLEAR;
                    if (wb_count_q != 16'hFFFF) wb_count_d = wb_count_q + 16'd1;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            wb_count_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Control outputs are pure state decodes so nothing combinational leaks from inputs.
    assign mem_wr_req = (state_q == ST_WRITE);
    assign vb_we      = (state_q == ST_CLEAR);
    assign roll       = (state_q == ST_DONE);
    assign evict_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = data_q;
    assign vb_wline   = idx_q;
    assign vb_wdata   = '0;
    assign wb_count   = wb_count_q;

endmodule

// File: doc/victim_writeback.md
# victim_writeback

Eviction and writeback engine for the 4-entry victim buffer. When the cache controller needs a victim slot freed, this block takes the entry at the buffer's current eviction pointer and writes it to main memory if it is valid and dirty. It then invalidates the slot through the buffer's write port and pulses `roll` to advance the eviction counter. It sits between the victim buffer's eviction outputs (entry data, eviction index) and the memory write channel.

## Interface
Parameters:
- `ADDR_W`, default 14: line address width.
- `DATA_W`, default 64: line data width.
- `ENTRY_W`, default `ADDR_W+DATA_W+2`: victim entry width, 80 at defaults; layout `{valid, dirty, addr, data}`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `evict_req` in 1: request to free the slot at the eviction pointer. Level-sampled.
- `ev_data` in `ENTRY_W`: entry at the eviction pointer.
- `ev_index` in 2: current eviction pointer.
- `mem_wr_req` out 1: memory write request.
- `mem_addr` out `ADDR_W`: write address.
- `mem_wdata` out `DATA_W`: write data.
- `mem_ack` in 1: memory accepted the write.
- `vb_we` out 1: victim buffer write strobe, used to invalidate the slot.
- `vb_wline` out 2: slot to write.
- `vb_wdata` out `ENTRY_W`: entry to write; always all-zero.
- `roll` out 1: one-cycle pulse that advances the buffer's eviction counter.
- `evict_done` out 1: one-cycle completion pulse, coincident with `roll`.
- `busy` out 1: high in every state except IDLE.
- `wb_count` out 16: number of completed dirty writebacks, saturating.

## Operation
FSM states: IDLE, EVAL, WRITE, CLEAR, DONE.

- **IDLE**
  - When `evict_req`=1: latch `ev_data` and `ev_index` into local registers, go to EVAL.
  - `evict_req` is ignored in every other state. Only one eviction is in flight at a time.
- **EVAL**
  - Latched valid=0 → DONE. No memory access, no clear.
  - Valid=1, dirty=0 → CLEAR.
  - Valid=1, dirty=1 → WRITE.
- **WRITE**
  - `mem_wr_req`=1, with `mem_addr` and `mem_wdata` driven from the latched entry and held stable.
  - On a cycle where `mem_ack`=1: increment `wb_count` (saturates at 0xFFFF), go to CLEAR.
  - No timeout; the block waits indefinitely.
- **CLEAR**
  - `vb_we`=1 for exactly one cycle, `vb_wline` = latched index, `vb_wdata`=0. Then go to DONE.
- **DONE**
  - `roll`=1 and `evict_done`=1 for one cycle, then IDLE.
  - `roll` fires on every eviction, including the invalid-slot case, so the pointer always advances.

Other rules:
- `mem_ack` outside WRITE is ignored and has no effect on `wb_count`.
- All datapath outputs come from latched registers. Changes on `ev_data` or `ev_index` after the request is accepted have no effect.
- `rst` mid-operation returns the FSM to IDLE the next cycle and drops `mem_wr_req` immediately. Any partial memory transaction is abandoned. The slot is not cleared and `roll` does not fire.

## Timing
- Reset values: `mem_wr_req`=0, `vb_we`=0, `roll`=0, `evict_done`=0, `busy`=0, `wb_count`=0, `mem_addr`/`mem_wdata`/`vb_wline`/`vb_wdata`=0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs.
- `evict_req` sampled high at edge T, for each entry type:
  - Invalid entry: EVAL at T+1, `evict_done` at T+2.
  - Clean entry: `vb_we` at T+2, `evict_done` at T+3.
  - Dirty entry: `mem_wr_req` rises at T+2.
- Dirty entry with `mem_ack` sampled at edge A (A ≥ T+2): `mem_wr_req` low from A+1, `vb_we` at A+1, `evict_done` at A+2.
- Earliest next acceptance is the cycle after DONE. `busy` is low in that cycle.
- Back-to-back clean evictions: one every 4 cycles.

## Structure
- Shared package `cache_pkg`:
  - FSM state enum.
  - `ENTRY_W`.
  - Field positions: `VB_VALID_BIT`=79, `VB_DIRTY_BIT`=78, `VB_ADDR_HI`=77, `VB_ADDR_LO`=64, `VB_DATA_HI`=63.
  - These are shared with the victim buffer.
- Single module, no sub-module. The saturating counter is inline.

## Test plan
1. Reset with `evict_req`=1 held → all outputs 0, `busy`=0 throughout reset.
2. Clean entry `{1,0,14'h0123,64'hDEAD}`, index 2 → `vb_we` at T+2 with `vb_wline`=2 and `vb_wdata`=0; `roll` at T+3; `mem_wr_req` never asserted.
3. Dirty entry with addr 14'h3FFF, data 64'h0123_4567_89AB_CDEF, `mem_ack` after 5 cycles → `mem_addr`/`mem_wdata` stable for all 5 cycles, `wb_count` 0→1, `vb_we` the cycle after ack, `roll` the cycle after that.
4. Invalid entry, index 0 → `evict_done`/`roll` at T+2, no `vb_we`, no `mem_wr_req`.
5. Stray `mem_ack` in IDLE, plus `evict_req` held high during WRITE → `wb_count` unchanged; exactly one eviction completes; the next eviction is accepted the cycle after DONE.
6. `rst` asserted during WRITE → IDLE next cycle, `mem_wr_req`=0, no `roll`. Also: with `wb_count` forced to 0xFFFF, a further dirty writeback leaves it at 0xFFFF.
